pc_sequencer: RTL and testbench

- Parametrised successor to the basic incrementing program counter.
- Adds a configurable step, absolute jump, conditional PC-relative branch, stall, and a hardware call/return stack of configurable depth.
- Sits in the fetch front end. It drives the instruction-memory address, and the decode stage supplies its opcode and target.

---
 rtl/pc_seq_pkg.sv | 11 +
 rtl/return_stack.sv | 54 +++++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared op encodings for the fetch-stage PC sequencer.
package pc_seq_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'd0;
    localparam logic [OP_W-1:0] OP_INC    = 3'd1;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd3;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd4;
    localparam logic [OP_W-1:0] OP_RET    = 3'd5;
endpackage

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses; push/pop commit at the clock edge, top is combinational.
// Latency: a pushed value is visible on top the next cycle. Push when full / pop when empty are ignored.
module return_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           full,
    output logic                           empty
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [AW-1:0]    wr_idx, top_idx;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign wr_idx  = AW'(depth_q);
    assign top_idx = AW'(depth_q - DW'(1));
    assign top     = mem_q[top_idx];
    assign depth   = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // Only the occupancy is reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: step/jump/branch/call/return with sticky stack-fault flags.
// Latency: pc updates one cycle after the op is sampled; en=0 stalls everything except clr_err.
// Optional macro PC_SEQ_TRAP_EN redirects stack faults to TRAP_VECTOR and pulses trap.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      STEP         = 1,
    parameter int unsigned      STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(16'hFFF0)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [OP_W-1:0]                    op,
    input  logic                               cond,
    input  logic [WIDTH-1:0]                   target,
    input  logic                               clr_err,
    output logic [WIDTH-1:0]                   pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               trap
);
`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             ovf_set, unf_set;
    logic             push, pop;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full, stk_empty;

    assign seq_pc = pc_q + STEP_W;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (seq_pc),
        .top   (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            case (op)
                OP_INC:    pc_d = seq_pc;
                OP_JUMP:   pc_d = target;
                // Two's-complement offset: a plain modular add gives signed behaviour.
                OP_BRANCH: pc_d = cond ? (pc_q + target) : seq_pc;
                OP_CALL: begin
                    if (!stk_full) begin
                        push = 1'b1;
                        pc_d = target;
                    end else begin
                        ovf_set = 1'b1;
                        pc_d    = TRAP_EN ? TRAP_VECTOR : target;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end else begin
                        unf_set = 1'b1;
                        pc_d    = TRAP_EN ? TRAP_VECTOR : seq_pc;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
        // A fault in the same cycle as clr_err keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc        = pc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef PC_SEQ_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= ovf_set | unf_set;
        end
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random ops against a queue-based model.
module tb_pc_sequencer;
`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [15:0] TVEC = 16'hFFF0;

    logic        clk = 1'b0;
    logic        rst, en, cond, clr_err;
    logic [2:0]  op;
    logic [15:0] target;
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        overflow, underflow, trap;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf, m_unf, m_trap;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .target(target),
        .clr_err(clr_err), .pc(pc), .depth(depth), .overflow(overflow),
        .underflow(underflow), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, input logic e, input logic [2:0] o,
                         input logic c, input logic [15:0] t, input logic clr);
        logic nov, nun;
        nov = 1'b0;
        nun = 1'b0;
        if (!r) begin
            m_pc = 16'h0000;
            m_stk.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_trap = 1'b0;
            return;
        end
        if (e) begin
            case (o)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = t;
                3'd3: m_pc = c ? m_pc + t : m_pc + 16'd1;
                3'd4: begin
                    if (m_stk.size() < 8) begin
                        m_stk.push_back(m_pc + 16'd1);
                        m_pc = t;
                    end else begin
                        nov  = 1'b1;
                        m_pc = TRAP ? TVEC : t;
                    end
                end
                3'd5: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        nun  = 1'b1;
                        m_pc = TRAP ? TVEC : m_pc + 16'd1;
                    end
                end
                default: ;
            endcase
        end
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (nov) m_ovf = 1'b1;
        if (nun) m_unf = 1'b1;
        m_trap = TRAP & (nov | nun);
    endtask

    task automatic apply(input logic r, input logic e, input logic [2:0] o,
                         input logic c, input logic [15:0] t, input logic clr);
        @(negedge clk);
        rst = r; en = e; op = o; cond = c; target = t; clr_err = clr;
        model(r, e, o, c, t, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        apply(1'b0, 1'b1, 3'd1, 1'b0, 16'h1234, 1'b0);
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        total++; if (depth !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0 || trap !== 1'b0) begin
            bad++; $display("FAIL reset_state got d=%0d o=%b u=%b t=%b exp all 0", depth, overflow, underflow, trap);
        end
        for (int i = 1; i <= 3; i++) begin
            apply(1'b1, 1'b1, 3'd1, 1'b0, 16'h0, 1'b0);
            total++; if (pc !== 16'(i)) begin bad++; $display("FAIL inc_%0d got=%h exp=%h", i, pc, 16'(i)); end
        end
        apply(1'b1, 1'b1, 3'd2, 1'b0, 16'hFFFF, 1'b0);
        apply(1'b1, 1'b1, 3'd1, 1'b0, 16'h0, 1'b0);
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL inc_wrap got=%h exp=0000", pc); end
    endtask

    task automatic test_stall_branch;
        apply(1'b1, 1'b1, 3'd2, 1'b0, 16'h0010, 1'b0);
        apply(1'b1, 1'b0, 3'd2, 1'b0, 16'h0100, 1'b0);
        total++; if (pc !== 16'h0010) begin bad++; $display("FAIL stall got=%h exp=0010", pc); end
        apply(1'b1, 1'b1, 3'd3, 1'b1, 16'hFFF8, 1'b0);
        total++; if (pc !== 16'h0008) begin bad++; $display("FAIL branch_taken got=%h exp=0008", pc); end
        apply(1'b1, 1'b1, 3'd3, 1'b0, 16'hFFF8, 1'b0);
        total++; if (pc !== 16'h0009) begin bad++; $display("FAIL branch_not_taken got=%h exp=0009", pc); end
        apply(1'b1, 1'b1, 3'd6, 1'b0, 16'h0777, 1'b0);
        total++; if (pc !== 16'h0009) begin bad++; $display("FAIL reserved_hold got=%h exp=0009", pc); end
    endtask

    task automatic test_nested_call;
        apply(1'b1, 1'b1, 3'd2, 1'b0, 16'h0020, 1'b0);
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h0100, 1'b0);
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h0200, 1'b0);
        total++; if (depth !== 4'd2 || pc !== 16'h0200) begin bad++; $display("FAIL call2 got d=%0d pc=%h exp d=2 pc=0200", depth, pc); end
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        total++; if (pc !== 16'h0101) begin bad++; $display("FAIL ret1 got=%h exp=0101", pc); end
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        total++; if (pc !== 16'h0021 || depth !== 4'd0) begin bad++; $display("FAIL ret2 got pc=%h d=%0d exp pc=0021 d=0", pc, depth); end
    endtask

    task automatic test_back_to_back;
        apply(1'b1, 1'b1, 3'd2, 1'b0, 16'h0050, 1'b0);
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h0300, 1'b0);
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        total++; if (pc !== 16'h0051 || depth !== 4'd0) begin bad++; $display("FAIL call_ret_b2b got pc=%h d=%0d exp pc=0051 d=0", pc, depth); end
    endtask

    task automatic test_overflow;
        apply(1'b0, 1'b1, 3'd0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h1000 + 16'(i), 1'b0);
        total++; if (depth !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL fill got d=%0d o=%b exp d=8 o=0", depth, overflow); end
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h0300, 1'b0);
        total++; if (depth !== 4'd8 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got d=%0d o=%b exp d=8 o=1", depth, overflow); end
        total++; if (pc !== (TRAP ? TVEC : 16'h0300) || trap !== TRAP) begin
            bad++; $display("FAIL ovf_pc got pc=%h t=%b exp pc=%h t=%b", pc, trap, TRAP ? TVEC : 16'h0300, TRAP);
        end
        apply(1'b1, 1'b1, 3'd0, 1'b0, 16'h0, 1'b0);
        total++; if (trap !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got t=%b o=%b exp t=0 o=1", trap, overflow); end
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h0400, 1'b1);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", overflow); end
        apply(1'b1, 1'b0, 3'd4, 1'b0, 16'h0, 1'b1);
        total++; if (overflow !== 1'b0 || depth !== 4'd8) begin bad++; $display("FAIL clr_ovf got o=%b d=%0d exp o=0 d=8", overflow, depth); end
    endtask

    task automatic test_underflow;
        apply(1'b0, 1'b1, 3'd0, 1'b0, 16'h0, 1'b0);
        apply(1'b1, 1'b1, 3'd2, 1'b0, 16'h0040, 1'b0);
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        total++; if (underflow !== 1'b1 || depth !== 4'd0) begin bad++; $display("FAIL unf_flag got u=%b d=%0d exp u=1 d=0", underflow, depth); end
        total++; if (pc !== (TRAP ? TVEC : 16'h0041) || trap !== TRAP) begin
            bad++; $display("FAIL unf_pc got pc=%h t=%b exp pc=%h t=%b", pc, trap, TRAP ? TVEC : 16'h0041, TRAP);
        end
        apply(1'b1, 1'b1, 3'd0, 1'b0, 16'h0, 1'b1);
        total++; if (underflow !== 1'b0 || trap !== 1'b0) begin bad++; $display("FAIL clr_unf got u=%b t=%b exp 0 0", underflow, trap); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h2000 + 16'(i), 1'b0);
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h2100, 1'b0);
        apply(1'b1, 1'b1, 3'd4, 1'b0, 16'h2200, 1'b0);
        apply(1'b0, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        total++; if (pc !== 16'h0000 || depth !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL reset_mid got pc=%h d=%0d o=%b u=%b exp 0 0 0 0", pc, depth, overflow, underflow);
        end
        apply(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL reset_mid_ret got u=%b exp=1", underflow); end
    endtask

    task automatic test_random;
        logic r, e, c, clr;
        logic [2:0] o;
        logic [15:0] t;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 99) != 0);
            e   = ($urandom_range(0, 9) != 0);
            c   = 1'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            // Call-heavy first third to reach a full stack, ret-heavy later.
            if (n < 1000 && $urandom_range(0, 2) == 0) o = 3'd4;
            else if (n >= 2000 && $urandom_range(0, 2) == 0) o = 3'd5;
            else o = 3'($urandom_range(0, 7));
            t = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed(5'($urandom)));
            apply(r, e, o, c, t, clr);
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
            total++; if (depth !== 4'(m_stk.size())) begin bad++; $display("FAIL rnd_depth n=%0d got=%0d exp=%0d", n, depth, m_stk.size()); end
            total++; if (overflow !== m_ovf || underflow !== m_unf) begin
                bad++; $display("FAIL rnd_flags n=%0d got o=%b u=%b exp o=%b u=%b", n, overflow, underflow, m_ovf, m_unf);
            end
            total++; if (trap !== m_trap) begin bad++; $display("FAIL rnd_trap n=%0d got=%b exp=%b", n, trap, m_trap); end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; op = 3'd0; cond = 1'b0; target = 16'h0; clr_err = 1'b0;
        m_pc = 16'h0; m_ovf = 1'b0; m_unf = 1'b0; m_trap = 1'b0;
        test_reset();
        test_stall_branch();
        test_nested_call();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
